reorder_buffer: RTL and testbench

In-order retirement buffer for the out-of-order core; sole producer of the architectural register file's retire write port. Allocates one entry per dispatched instruction in program order, accepts out-of-order completion results by tag, and retires at most one completed head entry per cycle as a registered write (`retire_valid`, `retire_reg`, `retire_reg_data`). A flush discards all in-flight entries.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/reorder_buffer.sv | 107 ++++++++++
 tb/tb_reorder_buffer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared core types: reorder-buffer entry layout and
// architectural sizes common to the ROB and register file.
package cpu_pkg;

  localparam int NUM_REG           = 32;
  localparam int NUM_REG_LOG2      = $clog2(NUM_REG);
  localparam int REG_SIZE          = 32;
  localparam int ROB_DEPTH_DEFAULT = 16;

  typedef struct packed {
    logic                    valid;
    logic                    done;
    logic [NUM_REG_LOG2-1:0] rd;
    logic [REG_SIZE-1:0]     data;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate in program order,
// complete by tag out of order, retire one head entry per cycle.
module reorder_buffer #(
  parameter int ROB_DEPTH    = cpu_pkg::ROB_DEPTH_DEFAULT,
  parameter int NUM_REG      = cpu_pkg::NUM_REG,
  parameter int NUM_REG_LOG2 = $clog2(NUM_REG),
  parameter int REG_SIZE     = cpu_pkg::REG_SIZE,
  parameter int TAG_W        = $clog2(ROB_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           dispatch_valid,
  input  logic [NUM_REG_LOG2-1:0]        dispatch_rd,
  output logic                           dispatch_ready,
  output logic [TAG_W-1:0]               dispatch_tag,
  input  logic                           complete_valid,
  input  logic [TAG_W-1:0]               complete_tag,
  input  logic [REG_SIZE-1:0]            complete_data,
  output logic                           retire_valid,
  output logic [NUM_REG_LOG2-1:0]        retire_reg,
  output logic [REG_SIZE-1:0]            retire_reg_data,
  output logic [$clog2(ROB_DEPTH+1)-1:0] rob_count,
  output logic                           rob_empty
);

  import cpu_pkg::rob_entry_t;

  localparam int CNT_W = $clog2(ROB_DEPTH + 1);

  rob_entry_t       rob [ROB_DEPTH];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic do_disp;
  logic do_comp;
  logic do_ret;

  // Status outputs come from registered state only.
  always_comb begin
    dispatch_ready = (count != CNT_W'(ROB_DEPTH));
    dispatch_tag   = tail;
    rob_count      = count;
    rob_empty      = (count == '0);
  end

  // Per-cycle event qualification.
  always_comb begin
    do_disp = dispatch_valid & dispatch_ready;
    do_comp = complete_valid & rob[complete_tag].valid;
    do_ret  = rob[head].valid & rob[head].done;
  end

  // Entry array, pointers, occupancy and retire register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rob[i] <= '0;
      end
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      retire_valid    <= 1'b0;
      retire_reg      <= '0;
      retire_reg_data <= '0;
    end else if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rob[i].valid <= 1'b0;
        rob[i].done  <= 1'b0;
      end
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      retire_valid <= 1'b0;
    end else begin
      retire_valid <= do_ret;
      if (do_ret) begin
        retire_reg      <= rob[head].rd;
        retire_reg_data <= rob[head].data;
      end
      // A repeat completion simply overwrites the result.
      if (do_comp) begin
        rob[complete_tag].done <= 1'b1;
        rob[complete_tag].data <= complete_data;
      end
      if (do_ret) begin
        rob[head].valid <= 1'b0;
        rob[head].done  <= 1'b0;
        head            <= head + 1'b1;
      end
      // Tail only equals a live slot when full, which blocks dispatch.
      if (do_disp) begin
        rob[tail].valid <= 1'b1;
        rob[tail].done  <= 1'b0;
        rob[tail].rd    <= dispatch_rd;
        tail            <= tail + 1'b1;
      end
      unique case ({do_disp, do_ret})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: vector table,
// directed corner sequences and random traffic vs a queue model.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        dispatch_valid = 1'b0;
  logic [4:0]  dispatch_rd = '0;
  logic        dispatch_ready;
  logic [3:0]  dispatch_tag;
  logic        complete_valid = 1'b0;
  logic [3:0]  complete_tag = '0;
  logic [31:0] complete_data = '0;
  logic        retire_valid;
  logic [4:0]  retire_reg;
  logic [31:0] retire_reg_data;
  logic [4:0]  rob_count;
  logic        rob_empty;

  int n_checks = 0;
  int n_errors = 0;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid),
    .dispatch_rd(dispatch_rd),
    .dispatch_ready(dispatch_ready),
    .dispatch_tag(dispatch_tag),
    .complete_valid(complete_valid),
    .complete_tag(complete_tag),
    .complete_data(complete_data),
    .retire_valid(retire_valid),
    .retire_reg(retire_reg),
    .retire_reg_data(retire_reg_data),
    .rob_count(rob_count),
    .rob_empty(rob_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    int          rd;
    bit          done;
    logic [31:0] data;
  } ment_t;

  ment_t       q[$];
  int          m_tail;
  bit          m_rv;
  int          m_rreg;
  logic [31:0] m_rdata;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_tail  = 0;
    m_rv    = 0;
    m_rreg  = 0;
    m_rdata = '0;
  endtask

  task automatic model_step(bit fl, bit dv, int rd, bit cv, int ct, logic [31:0] cd);
    bit rdy;
    bit ret;
    if (fl) begin
      q.delete();
      m_tail = 0;
      m_rv   = 0;
      return;
    end
    rdy = (q.size() < 16);
    ret = (q.size() > 0) && q[0].done;
    m_rv = ret;
    if (ret) begin
      m_rreg  = q[0].rd;
      m_rdata = q[0].data;
    end
    if (cv) begin
      foreach (q[i]) begin
        if (q[i].tag == ct) begin
          q[i].done = 1;
          q[i].data = cd;
        end
      end
    end
    if (ret) void'(q.pop_front());
    if (dv && rdy) begin
      q.push_back('{tag: m_tail, rd: rd, done: 0, data: '0});
      m_tail = (m_tail + 1) % 16;
    end
  endtask

  task automatic check_model(string nm);
    chk({nm, ".retire_valid"}, 32'(retire_valid), 32'(m_rv));
    chk({nm, ".retire_reg"}, 32'(retire_reg), 32'(m_rreg));
    chk({nm, ".retire_data"}, retire_reg_data, m_rdata);
    chk({nm, ".count"}, 32'(rob_count), 32'(q.size()));
    chk({nm, ".empty"}, 32'(rob_empty), 32'(q.size() == 0));
    chk({nm, ".ready"}, 32'(dispatch_ready), 32'(q.size() < 16));
    chk({nm, ".tag"}, 32'(dispatch_tag), 32'(m_tail));
  endtask

  // Apply one cycle of inputs, step the model, check after the edge.
  task automatic cyc(string nm, bit fl, bit dv, int rd,
                     bit cv, int ct, logic [31:0] cd);
    flush          = fl;
    dispatch_valid = dv;
    dispatch_rd    = 5'(rd);
    complete_valid = cv;
    complete_tag   = 4'(ct);
    complete_data  = cd;
    model_step(fl, dv, rd, cv, ct, cd);
    @(posedge clk);
    #1;
    flush          = 1'b0;
    dispatch_valid = 1'b0;
    complete_valid = 1'b0;
    check_model(nm);
  endtask

  task automatic check_reset_outputs(string nm);
    chk({nm, ".retire_valid"}, 32'(retire_valid), 0);
    chk({nm, ".retire_reg"}, 32'(retire_reg), 0);
    chk({nm, ".retire_data"}, retire_reg_data, 0);
    chk({nm, ".count"}, 32'(rob_count), 0);
    chk({nm, ".empty"}, 32'(rob_empty), 1);
    chk({nm, ".ready"}, 32'(dispatch_ready), 1);
    chk({nm, ".tag"}, 32'(dispatch_tag), 0);
  endtask

  task automatic do_reset(string nm);
    rst = 1'b1;
    #2;
    check_reset_outputs(nm);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    bit          dv;
    int          rd;
    bit          cv;
    int          ct;
    logic [31:0] cd;
    bit          rv;
    int          rreg;
    logic [31:0] rdata;
    int          cnt;
    int          tag;
  } vec_t;

  vec_t tbl[19];

  initial begin
    tbl[0]  = '{1, 5, 0, 0, 32'h0,        0, 0, 32'h0,        1, 1};
    tbl[1]  = '{0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 32'h0,        1, 1};
    tbl[2]  = '{0, 0, 0, 0, 32'h0,        1, 5, 32'hDEADBEEF, 0, 1};
    tbl[3]  = '{0, 0, 0, 0, 32'h0,        0, 5, 32'hDEADBEEF, 0, 1};
    tbl[4]  = '{1, 1, 0, 0, 32'h0,        0, 5, 32'hDEADBEEF, 1, 2};
    tbl[5]  = '{1, 2, 0, 0, 32'h0,        0, 5, 32'hDEADBEEF, 2, 3};
    tbl[6]  = '{1, 3, 0, 0, 32'h0,        0, 5, 32'hDEADBEEF, 3, 4};
    tbl[7]  = '{0, 0, 1, 3, 32'h33,       0, 5, 32'hDEADBEEF, 3, 4};
    tbl[8]  = '{0, 0, 1, 2, 32'h22,       0, 5, 32'hDEADBEEF, 3, 4};
    tbl[9]  = '{0, 0, 1, 1, 32'h11,       0, 5, 32'hDEADBEEF, 3, 4};
    tbl[10] = '{0, 0, 0, 0, 32'h0,        1, 1, 32'h11,       2, 4};
    tbl[11] = '{0, 0, 0, 0, 32'h0,        1, 2, 32'h22,       1, 4};
    tbl[12] = '{0, 0, 0, 0, 32'h0,        1, 3, 32'h33,       0, 4};
    tbl[13] = '{0, 0, 1, 1, 32'h99,       0, 3, 32'h33,       0, 4};
    tbl[14] = '{0, 0, 0, 0, 32'h0,        0, 3, 32'h33,       0, 4};
    tbl[15] = '{1, 7, 1, 4, 32'h44,       0, 3, 32'h33,       1, 5};
    tbl[16] = '{0, 0, 0, 0, 32'h0,        0, 3, 32'h33,       1, 5};
    tbl[17] = '{0, 0, 1, 4, 32'h45,       0, 3, 32'h33,       1, 5};
    tbl[18] = '{0, 0, 0, 0, 32'h0,        1, 7, 32'h45,       0, 5};

    model_reset();
    repeat (2) @(posedge clk);
    do_reset("reset");

    // Vector table: in-order, out-of-order, stale and early completions.
    for (int i = 0; i < 19; i++) begin
      cyc($sformatf("vec%0d", i), 0, tbl[i].dv, tbl[i].rd,
          tbl[i].cv, tbl[i].ct, tbl[i].cd);
      chk($sformatf("tbl%0d.rv", i), 32'(retire_valid), 32'(tbl[i].rv));
      chk($sformatf("tbl%0d.rreg", i), 32'(retire_reg), 32'(tbl[i].rreg));
      chk($sformatf("tbl%0d.rdata", i), retire_reg_data, tbl[i].rdata);
      chk($sformatf("tbl%0d.cnt", i), 32'(rob_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d.tag", i), 32'(dispatch_tag), 32'(tbl[i].tag));
    end

    // Full boundary and wrap.
    do_reset("reset_full");
    for (int i = 0; i < 16; i++) cyc("fill", 0, 1, i + 1, 0, 0, 0);
    chk("full.ready", 32'(dispatch_ready), 0);
    chk("full.count", 32'(rob_count), 16);
    cyc("full_comp", 0, 1, 20, 1, 0, 32'hA0);
    chk("full_comp.count", 32'(rob_count), 16);
    cyc("full_ret", 0, 1, 21, 0, 0, 0);
    chk("full_ret.rv", 32'(retire_valid), 1);
    chk("full_ret.rreg", 32'(retire_reg), 1);
    chk("full_ret.count", 32'(rob_count), 15);
    chk("full_ret.tag", 32'(dispatch_tag), 0);
    cyc("wrap_disp", 0, 1, 22, 0, 0, 0);
    chk("wrap_disp.count", 32'(rob_count), 16);
    chk("wrap_disp.tag", 32'(dispatch_tag), 1);

    // Flush with done head, same-cycle dispatch and completion.
    do_reset("reset_flush");
    for (int i = 0; i < 4; i++) cyc("fl_fill", 0, 1, i + 10, 0, 0, 0);
    cyc("fl_comp", 0, 0, 0, 1, 0, 32'h5A5A);
    cyc("flush", 1, 1, 30, 1, 1, 32'h77);
    chk("flush.count", 32'(rob_count), 0);
    chk("flush.rv", 32'(retire_valid), 0);
    chk("flush.tag", 32'(dispatch_tag), 0);
    cyc("fl_idle", 0, 0, 0, 0, 0, 0);
    cyc("fl_stale", 0, 0, 0, 1, 2, 32'h66);
    cyc("fl_idle2", 0, 0, 0, 0, 0, 0);
    chk("fl_idle2.rv", 32'(retire_valid), 0);

    // Register 0 still retires.
    cyc("r0_disp", 0, 1, 0, 0, 0, 0);
    cyc("r0_comp", 0, 0, 0, 1, 0, 32'hC0FFEE);
    cyc("r0_ret", 0, 0, 0, 0, 0, 0);
    chk("r0.rv", 32'(retire_valid), 1);
    chk("r0.rreg", 32'(retire_reg), 0);
    chk("r0.rdata", retire_reg_data, 32'hC0FFEE);

    // Asynchronous reset mid-stream.
    cyc("ar_disp", 0, 1, 9, 0, 0, 0);
    cyc("ar_comp", 0, 1, 8, 1, 1, 32'h1234);
    cyc("ar_ret", 0, 1, 7, 0, 0, 0);
    chk("ar_ret.rv", 32'(retire_valid), 1);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("async_rst_hold");
    rst = 1'b0;
    cyc("post_rst", 0, 1, 4, 0, 0, 0);
    chk("post_rst.count", 32'(rob_count), 1);

    // Random traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      bit          fl;
      bit          dv;
      bit          cv;
      int          ct;
      fl = ($urandom_range(0, 99) < 2);
      dv = ($urandom_range(0, 99) < 60);
      cv = ($urandom_range(0, 99) < 55);
      if (q.size() > 0 && $urandom_range(0, 99) < 75)
        ct = q[$urandom_range(0, q.size() - 1)].tag;
      else
        ct = $urandom_range(0, 15);
      cyc("rand", fl, dv, $urandom_range(0, 31), cv, ct, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
